mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Bus-interface stage directly upstream of the main memory.
- Accepts single read/write requests from the CPU datapath over a valid/ready handshake and drives the memory's address, wr and shared tri-state data bus.
- Sequences the memory's one-edge registered read: captures read data, then returns one response per request over valid/ready.
- Also keeps wrap-around read and write transaction counters for debug.

Parameters:
- DATA_WIDTH, 32, data bus and word width.
- ADDR_WIDTH, 27, word address width; matches the memory.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  controller can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU accepts response.
- resp_wr  output  1  response belongs to a write.
- resp_rdata  output  DATA_WIDTH  read data; holds last read value for writes.
- mem_address  output  ADDR_WIDTH  to memory address.
- mem_wr  output  1  to memory wr.
- mem_data  inout  DATA_WIDTH  shared memory data bus.
- rd_count  output  32  completed reads, wraps.
- wr_count  output  32  completed writes, wraps.

Behaviour:
- Reset (one clock with reset=1):
  - state=IDLE, mem_wr=0, mem_address=0, wdata register=0.
  - resp_valid=0, resp_wr=0, resp_rdata=0, rd_count=0, wr_count=0.
  - Reset has priority over all other events.
- FSM states: IDLE, WRITE, READ1, READ2, RESP.
- IDLE: req_ready=1. On posedge with req_valid=1:
  - Latch req_addr into mem_address and req_wdata into the wdata register.
  - If req_wr=1: mem_wr<=1, go to WRITE. Otherwise: mem_wr stays 0, go to READ1.
- WRITE: mem_wr=1 and mem_data driven with the wdata register; the memory writes on the next posedge. On that posedge: mem_wr<=0, wr_count+=1, resp_wr<=1, go to RESP.
- READ1: mem_wr=0, address stable; the memory registers mem[address] onto the bus on the next posedge. Go to READ2.
- READ2: on posedge, resp_rdata<=mem_data, rd_count+=1, resp_wr<=0, go to RESP.
- RESP: resp_valid=1. resp_rdata and resp_wr are stable until the handshake. On posedge with resp_ready=1: resp_valid<=0, go to IDLE.
- req_ready=0 in every state except IDLE; there is no request buffering and no pipelining.
- Latency, counted from the accept edge E0:
  - Write response valid after E1.
  - Read response valid after E2.
  - Minimum request-to-request throughput: 3 cycles for a write, 4 cycles for a read, assuming resp_ready is held 1.
- Tri-state: mem_data is driven only when mem_wr=1, otherwise high-Z. Because one register controls both wr and the driver enable, the memory and the controller never drive the bus in the same cycle.
- mem_address and mem_wr change only on posedge; they are glitch-free registered outputs.
- Counters wrap from 0xFFFFFFFF to 0 with no flag.
- Reset asserted in WRITE: the memory still sees wr=1 at that edge and completes the write, because the memory has no reset. Controller state is cleared, no response is issued and wr_count is unaffected.
- Reset asserted in READ1, READ2 or RESP: the transaction is dropped and no response is issued.
- req_valid held high while in RESP does not queue a request; it is accepted only in IDLE.
- Request fields are sampled only at the accept edge; later changes are ignored.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum encoding (IDLE=0, WRITE=1, READ1=2, READ2=3, RESP=4, 3 bits);
  - default DATA_WIDTH / ADDR_WIDTH constants, shared with the memory instance;
  - the counter width constant (32).
- No sub-module: the FSM, registers, tri-state assign and counters stay in one module of roughly 150-200 lines.

Test Plan:
- Write then read: write addr 0x0000010 = 0xDEADBEEF with resp_ready=1, then read addr 0x0000010. Required:
  - resp_valid is asserted 1 cycle after the write accept and 2 cycles after the read accept;
  - read resp_rdata = 0xDEADBEEF with resp_wr=0;
  - wr_count=1, rd_count=1.
- Back-to-back mix: req_valid held 1 for write 0x5=0x11111111, write 0x6=0x22222222, read 0x5, read 0x6. Required: req_ready pulses once per transaction, reads return 0x11111111 then 0x22222222, counters end at 2/2.
- Response stall: read with resp_ready=0 for 5 cycles after resp_valid. Required: resp_valid and resp_rdata stay stable, req_ready stays 0, a new req_valid is not accepted until one cycle after the resp_ready handshake.
- Bus contention check: on every cycle of the above runs, assert mem_data is high-Z from the controller whenever mem_wr=0, and mem_data equals the wdata register whenever mem_wr=1; no X appears on the bus during writes.
- Reset mid-read: issue a read, assert reset in READ2. Required: next cycle state=IDLE, resp_valid=0, rd_count=0, mem_wr=0, req_ready=1, and no response ever appears.
- Reset mid-write: write addr 0x7=0xCAFEF00D, assert reset during WRITE, release, then read 0x7. Required: reads 0xCAFEF00D, wr_count=0, rd_count=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths and FSM state encoding for the memory bus controller
package mem_bus_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 27;
    localparam int CNT_WIDTH      = 32;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ1 = 3'd2;
    localparam state_t ST_READ2 = 3'd3;
    localparam state_t ST_RESP  = 3'd4;
endpackage

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding request sequencer driving a registered-read memory over a shared tri-state bus
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_wr,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);
    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    assign req_ready  = state == ST_IDLE;
    assign resp_valid = state == ST_RESP;
    // mem_wr doubles as the driver enable, so the memory and this block never drive together
    assign mem_data   = mem_wr ? wdata_q : {DATA_WIDTH{1'bz}};
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_wr      <= 1'b0;
            mem_address <= '0;
            wdata_q     <= '0;
            resp_wr     <= 1'b0;
            resp_rdata  <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    mem_address <= req_addr;
                    wdata_q     <= req_wdata;
                    mem_wr      <= req_wr;
                    state       <= req_wr ? ST_WRITE : ST_READ1;
                end
                ST_WRITE: begin
                    mem_wr   <= 1'b0;
                    wr_count <= wr_count + 1'b1;
                    resp_wr  <= 1'b1;
                    state    <= ST_RESP;
                end
                ST_READ1: state <= ST_READ2;
                ST_READ2: begin
                    resp_rdata <= mem_data;
                    rd_count   <= rd_count + 1'b1;
                    resp_wr    <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RESP: if (resp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: scoreboard bench with a registered-read memory model on the shared bus
module tb_mem_bus_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [26:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_wr;
    logic [31:0] resp_rdata;
    logic [26:0] mem_address;
    logic        mem_wr;
    wire  [31:0] mem_data;
    logic [31:0] rd_count, wr_count;

    mem_bus_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
        .resp_rdata(resp_rdata), .mem_address(mem_address), .mem_wr(mem_wr),
        .mem_data(mem_data), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    // memory: writes on the edge while wr=1, registers mem[address] onto the bus otherwise
    logic [31:0] mem [0:255];
    logic [31:0] mem_q;
    assign mem_data = mem_wr ? 32'bz : mem_q;
    always @(posedge clock) begin
        if (mem_wr) mem[mem_address[7:0]] <= mem_data;
        mem_q <= mem[mem_address[7:0]];
    end

    int n_tests = 0, n_fail = 0, cyc = 0, rdy_cycles = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] mdl [0:255];
    logic [31:0] last_rd = 0, exp_wdata = 0;
    logic        prev_valid = 0;

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            last_rd    = 0;
            prev_valid = 0;
        end else begin
            if (mem_wr) check("bus_wdata", mem_data, exp_wdata);
            if (req_ready) rdy_cycles++;
            if (resp_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_resp", 32'(1), 32'(0));
                else check("latency", 32'(cyc - sb[0].acc), sb[0].wr ? 32'd1 : 32'd2);
            end
            if (resp_valid && resp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_wr", 32'(resp_wr), 32'(e.wr));
                check("resp_rdata", resp_rdata, e.data);
            end
            if (req_valid && req_ready) begin
                if (req_wr) begin
                    mdl[req_addr[7:0]] = req_wdata;
                    exp_wdata = req_wdata;
                    sb.push_back('{1'b1, last_rd, cyc + 1});
                end else begin
                    last_rd = mdl[req_addr[7:0]];
                    sb.push_back('{1'b0, last_rd, cyc + 1});
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic send(input logic wr, input logic [26:0] a, input logic [31:0] d);
        int n;
        req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clock);
            if (req_ready) break;
        end
        if (n == 50) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clock); #1;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        if (n == 100) check("drain_timeout", 32'(sb.size()), 32'(0));
        @(posedge clock); #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    logic [31:0] held;
    initial begin
        reset = 1'b1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_resp_wr", 32'(resp_wr), 32'(0));
        check("rst_resp_rdata", resp_rdata, 32'(0));
        check("rst_rd_count", rd_count, 32'(0));
        check("rst_wr_count", wr_count, 32'(0));
        check("rst_mem_wr", 32'(mem_wr), 32'(0));
        check("rst_mem_address", 32'(mem_address), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(1));
        @(posedge clock); #1;

        send(1'b1, 27'h10, 32'hDEADBEEF);
        req_valid = 0; req_wdata = 32'h0BADF00D;
        drain();
        send(1'b0, 27'h10, 32'h0);
        req_valid = 0; req_addr = 27'h55;
        drain();
        check("wr_count_1", wr_count, 32'(1));
        check("rd_count_1", rd_count, 32'(1));

        rst_pulse();
        rdy_cycles = 0;
        send(1'b1, 27'h5, 32'h11111111);
        send(1'b1, 27'h6, 32'h22222222);
        send(1'b0, 27'h5, 32'h0);
        send(1'b0, 27'h6, 32'h0);
        check("b2b_ready_pulses", 32'(rdy_cycles), 32'(4));
        req_valid = 0;
        drain();
        check("b2b_wr_count", wr_count, 32'(2));
        check("b2b_rd_count", rd_count, 32'(2));

        resp_ready = 0;
        send(1'b0, 27'h5, 32'h0);
        req_valid = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (resp_valid) break;
        end
        check("stall_valid", 32'(resp_valid), 32'(1));
        check("stall_rdata", resp_rdata, 32'h11111111);
        held = resp_rdata;
        @(posedge clock); #1;
        req_valid = 1; req_wr = 1; req_addr = 27'h9; req_wdata = 32'h99999999;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check("stall_hold_valid", 32'(resp_valid), 32'(1));
            check("stall_hold_rdata", resp_rdata, held);
            check("stall_req_ready", 32'(req_ready), 32'(0));
        end
        @(posedge clock); #1;
        resp_ready = 1;
        @(negedge clock);
        @(negedge clock);
        check("post_hs_ready", 32'(req_ready), 32'(1));
        check("post_hs_valid", 32'(resp_valid), 32'(0));
        @(posedge clock); #1;
        req_valid = 0;
        drain();

        send(1'b0, 27'h5, 32'h0);
        req_valid = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rrd_req_ready", 32'(req_ready), 32'(1));
        check("rrd_resp_valid", 32'(resp_valid), 32'(0));
        check("rrd_rd_count", rd_count, 32'(0));
        check("rrd_mem_wr", 32'(mem_wr), 32'(0));
        repeat (10) @(negedge clock);
        @(posedge clock); #1;

        send(1'b1, 27'h7, 32'hCAFEF00D);
        req_valid = 0;
        rst_pulse();
        send(1'b0, 27'h7, 32'h0);
        req_valid = 0;
        drain();
        check("rwr_wr_count", wr_count, 32'(0));
        check("rwr_rd_count", rd_count, 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
